// File: rtl/amber48_uart_pkg.sv
// Shared UART types: arbiter state encoding and counter-width helpers.
package amber48_uart_pkg;

  typedef enum logic {ARB, OWN} uart_arb_state_e;

  // Counter width for a count that must reach n-1, never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  localparam int ARB_BURST_CNT_W = cnt_w(64);
  localparam int ARB_IDLE_CNT_W  = cnt_w(1024);

endpackage

// File: rtl/amber48_rr_pick.sv
// Combinational round-robin pick: first set bit of req searching upward from ptr, modulo N.
module amber48_rr_pick #(
  parameter int N = 3,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  int k;

  // Walk offsets high to low so the smallest offset from ptr is the last writer.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    k     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % N;
      if (req[k]) begin
        found = 1'b1;
        idx   = W'(k);
      end
    end
  end

endmodule

// File: rtl/amber48_uart_tx_arb.sv
// Message-granular round-robin arbiter feeding one UART TX byte port,
// with per-grant burst and idle-timeout bounds.
module amber48_uart_tx_arb
  import amber48_uart_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int MAX_BURST    = 64,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*8-1:0]       req_data_i,
  input  logic [NUM_REQ-1:0]         req_last_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [7:0]                 tx_data_o,
  output logic                       tx_valid_o,
  input  logic                       tx_ready_i,
  output logic [$clog2(NUM_REQ)-1:0] grant_o,
  output logic                       busy_o
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = cnt_w(MAX_BURST);
  localparam int IW = cnt_w(IDLE_TIMEOUT);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $fatal(1, "amber48_uart_tx_arb: NUM_REQ=%0d outside 2..8", NUM_REQ);
  end
  if (MAX_BURST < 1 || MAX_BURST > 256) begin : g_bad_burst
    $fatal(1, "amber48_uart_tx_arb: MAX_BURST=%0d outside 1..256", MAX_BURST);
  end
  if (IDLE_TIMEOUT < 1) begin : g_bad_timeout
    $fatal(1, "amber48_uart_tx_arb: IDLE_TIMEOUT=%0d below 1", IDLE_TIMEOUT);
  end

  logic [NUM_REQ-1:0][7:0] data_arr;
  uart_arb_state_e         state_q, state_d;
  logic [GW-1:0]           grant_q, grant_d, ptr_q, ptr_d, pick_idx;
  logic [BW-1:0]           byte_q, byte_d;
  logic [IW-1:0]           idle_q, idle_d;
  logic                    pick_found, g_valid, g_last, xfer, rel;

  assign data_arr = req_data_i;
  assign g_valid  = req_valid_i[grant_q];
  assign g_last   = req_last_i[grant_q];
  assign xfer     = g_valid & tx_ready_i;

  amber48_rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (req_valid_i),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    byte_d      = byte_q;
    idle_d      = idle_q;
    rel         = 1'b0;
    tx_valid_o  = 1'b0;
    tx_data_o   = 8'h00;
    req_ready_o = '0;
    unique case (state_q)
      ARB: begin
        if (pick_found) begin
          grant_d = pick_idx;
          byte_d  = '0;
          idle_d  = '0;
          state_d = OWN;
        end
      end
      OWN: begin
        tx_valid_o           = g_valid;
        tx_data_o            = data_arr[grant_q];
        req_ready_o[grant_q] = tx_ready_i;
        if (xfer) byte_d = byte_q + 1'b1;
        idle_d = g_valid ? '0 : idle_q + 1'b1;
        // Backpressure keeps valid high, so tx_ready_i stalls never age the grant.
        rel = (xfer && (g_last || byte_q == BW'(MAX_BURST - 1))) ||
              (!g_valid && idle_q == IW'(IDLE_TIMEOUT - 1));
        if (rel) begin
          state_d = ARB;
          ptr_d   = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB;
      grant_q <= '0;
      ptr_q   <= '0;
      byte_q  <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      byte_q  <= byte_d;
      idle_q  <= idle_d;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q == OWN);

endmodule

// File: doc/amber48_uart_tx_arb.md
# amber48_uart_tx_arb

Round-robin arbiter that shares one `amber48_uart_tx` byte transmitter between `NUM_REQ` byte-stream requesters, such as the debug monitor, the CPU console and the boot loader. A requester holds its grant for a whole message, ending at a byte marked `last`, so messages are never interleaved on the wire. Bounds stop a stalled or verbose requester from starving the others. The block sits between the requester byte streams and the single UART TX instance.

## Interface
- `NUM_REQ`, default 3: number of requesters, 2..8.
- `MAX_BURST`, default 64: maximum bytes accepted per grant, 1..256.
- `IDLE_TIMEOUT`, default 1024: cycles with the granted requester's `valid` low before its grant is revoked, ≥1.
- `clk_i` in, 1: clock.
- `rst_i` in, 1: reset, synchronous, active-high.
- `req_valid_i` in, `NUM_REQ`: per-requester byte valid.
- `req_data_i` in, `NUM_REQ`×8: per-requester byte, packed, requester k at [8k+7:8k].
- `req_last_i` in, `NUM_REQ`: marks the final byte of a message.
- `req_ready_o` out, `NUM_REQ`: per-requester byte accepted.
- `tx_data_o` out, 8: byte to the UART TX `data_i`.
- `tx_valid_o` out, 1: to the UART TX `valid_i`.
- `tx_ready_i` in, 1: from the UART TX `ready_o`.
- `grant_o` out, `$clog2(NUM_REQ)`: index of the current owner, valid while `busy_o`.
- `busy_o` out, 1: a grant is held.

## Operation
- States: `ARB`, `OWN`. Reset enters `ARB`.
- Reset values: rr pointer 0, `grant_o`=0, byte count 0, idle count 0.
- Reset outputs: `busy_o`=0, `tx_valid_o`=0, `req_ready_o`=0, `tx_data_o`=0.
- `ARB`:
  - No bytes are forwarded in this state.
  - Pick the first requester with `req_valid_i` set, searching from the rr pointer upward modulo `NUM_REQ`.
  - If one is found, register it into `grant_o`, clear both counters and go to `OWN`.
  - If none is found, stay in `ARB`.
- `OWN`, requester g = `grant_o`:
  - `tx_valid_o` = `req_valid_i[g]`.
  - `tx_data_o` = `req_data_i[g]`.
  - `req_ready_o[g]` = `tx_ready_i`. All other `req_ready_o` bits are 0.
  - These paths are combinational, with no added latency.
- Transfer: a byte is transferred when `req_valid_i[g] & tx_ready_i`. Each transfer increments the byte count.
- Release: the grant is released and the block returns to `ARB` on the first of these:
  - a transfer with `req_last_i[g]`=1;
  - a transfer with byte count == `MAX_BURST`-1;
  - idle count reaching `IDLE_TIMEOUT`-1 while `req_valid_i[g]`=0.
- On release, the rr pointer becomes g+1, wrapping from `NUM_REQ`-1 to 0.
- Idle count:
  - increments each `OWN` cycle with `req_valid_i[g]`=0;
  - clears on any cycle with `req_valid_i[g]`=1.
  - Stalls caused by `tx_ready_i`=0 never count toward the timeout.
- Outside `OWN`, `tx_valid_o`=0, `tx_data_o`=0 and all `req_ready_o`=0.
- Requesters must hold `valid`, `data` and `last` stable until `ready` is seen. The block does not check this.
- A requester dropped by burst limit or timeout re-competes normally. Its next bytes are treated as a continuation; no framing is inserted.

## Timing
- Request to grant: 1 cycle, spent in `ARB`. The earliest forwarded `tx_valid_o` is the cycle after `req_valid_i` first rises.
- Back-to-back messages: one dead cycle (`ARB`) between the last transfer of one grant and the next grant. This is negligible against the UART character time.
- Simultaneous release and a new request from the same requester: that requester is lowest priority for the next arbitration.
- `rst_i` asserted mid-message: the next edge forces `ARB` and reset values.
  - The current byte is dropped from the arbiter's view.
  - A byte already latched by the UART TX completes on the wire, since its reset is independent.

## Structure
- Add to shared package `amber48_uart_pkg`:
  - `uart_arb_state_e` {`ARB`, `OWN`};
  - localparams for count widths: `$clog2(MAX_BURST)`, `$clog2(IDLE_TIMEOUT)`, with a minimum of 1 bit.
- Sub-module `amber48_rr_pick`: combinational, parameter N; inputs `req[N]` and `ptr`; outputs `found` and `idx`. It is reused later by the IRQ controller.
- Elaboration `$fatal` if any parameter is outside its stated range.

## Test plan
- Single requester: r1 sends 0x41, 0x42, 0x43 (last on 0x43) with `tx_ready_i` toggling every 3 cycles. Expect exactly 3 transfers in order, then `busy_o`=0 one cycle after the last transfer.
- Contention: r0 and r2 each hold a 2-byte message from reset. Expect grant r0 first (pointer 0), sequence 0x10, 0x11 then 0x20, 0x21, no interleaving, one `ARB` cycle between grants.
- Fairness: all 3 requesters request continuously with 1-byte messages. Expect grant order 0, 1, 2, 0, 1, 2.
- Burst limit (`MAX_BURST`=4): r0 streams 10 bytes without `last` while r1 waits. Expect r0 released after its 4th transfer, r1 granted next.
- Timeout (`IDLE_TIMEOUT`=8): r2 sends 1 byte, then drops valid. Expect release after 8 idle cycles. With `tx_ready_i` held 0 and `req_valid_i[2]`=1 for 50 cycles, expect no release.
- Reset: assert `rst_i` while granted mid-message. Expect all outputs at reset values next cycle, and a subsequent grant starting from requester 0.
